csync_gen: RTL and testbench

Parametrised composite-sync generator for the video output path, sitting between the video timing generator and the analogue/SCART output stage. It normalises input sync polarity and measures line period and HSync width. It produces a registered composite sync in one of four runtime-selectable modes, including serrated VSync, plus polarity-normalised separate H/V syncs and a lock flag.

---
 rtl/csync_gen.sv | 147 ++++++++++++++
 tb/tb_csync_gen.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/csync_gen.sv
// Composite-sync generator: normalises H/V sync polarity, measures line period
// and HSync width, and builds OR / XOR / serrated / H-only composite sync.
// Optional polarity auto-detection is built when CSYNC_POL_DETECT_EN is defined.
module csync_gen #(
  parameter int CNT_W   = 16,
  parameter bit OUT_NEG = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] mode,
  input  logic       hsync_in,
  input  logic       vsync_in,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic       csync_out,
  output logic       locked
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             hs_r, vs_r, hs_d;
  logic             h_pol, v_pol;
  logic             hs, vs, hs_rise, hs_fall;
  logic [CNT_W-1:0] p_cnt, line_len, hs_len, p_inc;
  logic [1:0]       mode_q, mode_eff;
  logic             lock_nxt, lock_eff, serr_ok, comp;
  logic [CNT_W-1:0] len_eff, gap_start;
  logic [CNT_W:0]   pos;

  assign hs      = hs_r ^ h_pol;
  assign vs      = vs_r ^ v_pol;
  assign hs_rise = hs & ~hs_d;
  assign hs_fall = ~hs & hs_d;

  // Saturating p_cnt + 1, so a stalled line never wraps into a bogus short period.
  assign p_inc    = (p_cnt == CNT_MAX) ? CNT_MAX : p_cnt + CNT_W'(1);
  assign lock_nxt = (p_inc == line_len) && (line_len != '0);

  // On the line-start cycle itself, use the values being loaded so the new line
  // is coherent from its first cycle.
  assign mode_eff  = hs_rise ? mode : mode_q;
  assign len_eff   = hs_rise ? p_inc : line_len;
  assign lock_eff  = hs_rise ? lock_nxt : locked;
  assign pos       = hs_rise ? '0 : ({1'b0, p_cnt} + (CNT_W+1)'(1));
  assign gap_start = len_eff - hs_len;
  assign serr_ok   = lock_eff && (len_eff > hs_len);

  always_comb begin
    comp = hs;
    case (mode_eff)
      2'd0: comp = hs | vs;
      2'd1: comp = hs ^ vs;
      2'd2: begin
        if (vs) comp = serr_ok ? (pos < {1'b0, gap_start}) : (hs ^ vs);
      end
      default: comp = hs;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hs_r      <= 1'b0;
      vs_r      <= 1'b0;
      hs_d      <= 1'b0;
      p_cnt     <= '0;
      line_len  <= '0;
      hs_len    <= '0;
      locked    <= 1'b0;
      mode_q    <= 2'd1;
      hsync_out <= OUT_NEG;
      vsync_out <= OUT_NEG;
      csync_out <= OUT_NEG;
    end else begin
      hs_r <= hsync_in;
      vs_r <= vsync_in;
      hs_d <= hs;
      if (hs_rise) begin
        p_cnt    <= '0;
        line_len <= p_inc;
        locked   <= lock_nxt;
        mode_q   <= mode;
      end else begin
        if (p_cnt != CNT_MAX) p_cnt <= p_inc;
        else                  locked <= 1'b0;
      end
      if (hs_fall) hs_len <= p_inc;
      hsync_out <= hs ^ OUT_NEG;
      vsync_out <= vs ^ OUT_NEG;
      csync_out <= comp ^ OUT_NEG;
    end
  end

`ifdef CSYNC_POL_DETECT_EN
  logic             hs_r_d, vs_r_d;
  logic [CNT_W-1:0] h_hi, h_lo, h_hi_len;
  logic [10:0]      v_hi, v_lo, v_hi_len;

  // The shorter phase of each raw input is taken as the active phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      hs_r_d   <= 1'b0;
      vs_r_d   <= 1'b0;
      h_hi     <= '0;
      h_lo     <= '0;
      h_hi_len <= '0;
      v_hi     <= '0;
      v_lo     <= '0;
      v_hi_len <= '0;
      h_pol    <= 1'b0;
      v_pol    <= 1'b0;
    end else begin
      hs_r_d <= hs_r;
      vs_r_d <= vs_r;
      if (hs_r && !hs_r_d) begin
        h_pol <= (h_hi_len > h_lo);
        h_hi  <= CNT_W'(1);
        h_lo  <= '0;
      end else if (!hs_r && hs_r_d) begin
        h_hi_len <= h_hi;
        h_lo     <= CNT_W'(1);
      end else if (hs_r) begin
        if (h_hi != CNT_MAX) h_hi <= h_hi + CNT_W'(1);
      end else begin
        if (h_lo != CNT_MAX) h_lo <= h_lo + CNT_W'(1);
      end
      if (vs_r && !vs_r_d) begin
        if (locked) v_pol <= (v_hi_len > v_lo);
        v_hi <= '0;
        v_lo <= '0;
      end else if (!vs_r && vs_r_d) begin
        v_hi_len <= v_hi;
        v_lo     <= '0;
      end else if (hs_rise) begin
        if (vs_r) begin
          if (v_hi != 11'h7ff) v_hi <= v_hi + 11'd1;
        end else begin
          if (v_lo != 11'h7ff) v_lo <= v_lo + 11'd1;
        end
      end
    end
  end
`else
  assign h_pol = 1'b0;
  assign v_pol = 1'b0;
`endif

endmodule

// File: tb/tb_csync_gen.sv
// Self-checking bench for csync_gen: randomized line/VSync/mode stimulus compared
// against a line-level behavioural model of the composite-sync rules.
module tb_csync_gen;
  localparam int CNT_W   = 12;
  localparam bit OUT_NEG = 1'b1;
  localparam int MAXC    = (1 << CNT_W) - 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] mode = 2'd1;
  logic       hsync_in = 1'b0;
  logic       vsync_in = 1'b0;
  logic       hsync_out, vsync_out, csync_out, locked;

  csync_gen #(.CNT_W(CNT_W), .OUT_NEG(OUT_NEG)) dut (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode),
    .hsync_in  (hsync_in),
    .vsync_in  (vsync_in),
    .hsync_out (hsync_out),
    .vsync_out (vsync_out),
    .csync_out (csync_out),
    .locked    (locked)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Scoreboard: {hsync_out, vsync_out, csync_out, locked}, two cycles behind input
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  string      phase = "reset";
  logic [3:0] exp_q[$];
  localparam logic [3:0] IDLE = {OUT_NEG, OUT_NEG, OUT_NEG, 1'b0};

  // Reference model state, at the level of "lines": when the last line began,
  // the last measured period and HSync width, lock flag, and latched mode.
  int last_rise, m_line_len, m_hs_len, m_mode_q;
  bit m_lock, m_prev_h;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got(h,v,c,lock)=%b expected=%b", tag, cyc, got, exp);
    end
  endtask

  task automatic model_step(input bit h, input bit v, input int md, input bit rst,
                            output logic [3:0] e);
    int pc, inc, pos;
    bit rise, fall, c;
    if (rst) begin
      last_rise  = cyc - 1;
      m_line_len = 0;
      m_hs_len   = 0;
      m_lock     = 0;
      m_mode_q   = 1;
      m_prev_h   = 0;
      e = IDLE;
      return;
    end
    pc  = cyc - last_rise - 1;
    if (pc > MAXC) pc = MAXC;
    inc  = (pc + 1 > MAXC) ? MAXC : pc + 1;
    rise = h && !m_prev_h;
    fall = !h && m_prev_h;
    if (rise) begin
      m_lock     = (inc == m_line_len) && (m_line_len != 0);
      m_line_len = inc;
      m_mode_q   = md;
      last_rise  = cyc;
      pos        = 0;
    end else begin
      pos = pc + 1;
    end
    case (m_mode_q)
      0: c = h | v;
      1: c = h ^ v;
      2: begin
        if (!v) c = h;
        else if (m_lock && m_line_len > m_hs_len) c = (pos < m_line_len - m_hs_len);
        else c = h ^ v;
      end
      default: c = h;
    endcase
    if (fall) m_hs_len = inc;
    if (!rise && pc == MAXC) m_lock = 0;
    m_prev_h = h;
    e = {h ^ OUT_NEG, v ^ OUT_NEG, c ^ OUT_NEG, m_lock};
  endtask

  // Driver: sample on the falling edge, then apply the next input set
  task automatic drive(input bit h, input bit v, input logic [1:0] md, input bit rst);
    logic [3:0] e;
    @(negedge clk);
    if (exp_q.size() >= 2)
      check(phase, {hsync_out, vsync_out, csync_out, locked}, exp_q.pop_front());
    hsync_in = h;
    vsync_in = v;
    mode     = md;
    reset    = rst;
    model_step(h, v, int'(md), rst, e);
    if (rst) begin
      exp_q.delete();
      exp_q.push_back(IDLE);
    end
    exp_q.push_back(e);
    cyc++;
  endtask

  task automatic line(input int len, input int hw, input bit v,
                      input logic [1:0] ma, input logic [1:0] mb, input int chg);
    for (int k = 0; k < len; k++)
      drive(k < hw, v, (k < chg) ? ma : mb, 1'b0);
  endtask

  initial begin
    int len, hw;
    bit v;
    logic [1:0] ma, mb;
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 2'd1, 1'b1);

    phase = "xor_lock";
    for (int i = 0; i < 6; i++) line(64, 8, (i >= 3 && i < 5), 2'd1, 2'd1, 64);

    phase = "serrated";
    for (int i = 0; i < 8; i++) line(64, 8, (i >= 3 && i < 6), 2'd2, 2'd2, 64);

    phase = "mode_change";
    line(64, 8, 1'b1, 2'd1, 2'd0, 20);
    line(64, 8, 1'b1, 2'd0, 2'd0, 64);
    line(64, 8, 1'b0, 2'd0, 2'd0, 64);

    phase = "random";
    len = 64; hw = 8;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        len = $urandom_range(40, 80);
        hw  = $urandom_range(2, 12);
      end
      v  = ($urandom_range(0, 3) == 0);
      ma = 2'($urandom_range(0, 3));
      mb = 2'($urandom_range(0, 3));
      line(len, hw, v, ma, mb, $urandom_range(0, len));
    end

    phase = "reset_mid_vsync";
    for (int i = 0; i < 3; i++) line(64, 8, 1'b1, 2'd2, 2'd2, 64);
    line(30, 8, 1'b1, 2'd2, 2'd2, 30);
    drive(1'b0, 1'b1, 2'd2, 1'b1);
    for (int i = 0; i < 5; i++) line(64, 8, (i >= 2), 2'd2, 2'd2, 64);

    phase = "hsync_stopped";
    for (int i = 0; i < MAXC + 100; i++) drive(1'b0, 1'b1, 2'd2, 1'b0);
    for (int i = 0; i < 4; i++) line(64, 8, 1'b1, 2'd2, 2'd2, 64);

    phase = "drain";
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 2'd2, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
